uart_echo_cpu: RTL and testbench

Fixed-function serial echo processor for the FPGA top level. It receives 8N1 UART characters on `serial_in`, queues them, and retransmits each byte unchanged on `serial_out` in arrival order. It stands in for the processor's memory-mapped UART path, so the host serial link can be brought up and verified end to end.

---
 rtl/uart_echo_cpu.sv | 207 ++++++++++++++++++++
 tb/tb_uart_echo_cpu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_cpu.sv
// Serial echo engine: 8N1 receiver -> circular byte queue -> 8N1 transmitter.
// Every good received byte is retransmitted unchanged, in arrival order.
module uart_echo_cpu #(
    parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    output logic serial_out
);
    localparam int unsigned Symbol = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CntW   = $clog2(Symbol) + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] SymLast  = CntW'(Symbol - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(Symbol / 2 - 1);
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxSend} tx_state_e;

    // ---------------------------------------------------------------- RX
    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            push;

    // Synchronizer flops reset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push       = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == SymLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == SymLast) begin
                    rx_cnt_d   = '0;
                    push       = rx_sync_q;
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // -------------------------------------------------------------- FIFO
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   fifo_cnt_q, fifo_cnt_d;
    logic            fifo_full, fifo_empty, wr_en, pop, tx_ready;
    logic [7:0]      fifo_rdata;

    assign fifo_full  = (fifo_cnt_q == FifoFull);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = tx_ready && !fifo_empty;
    // A simultaneous pop frees the slot, so a full queue still accepts the byte.
    assign wr_en      = push && (!fifo_full || pop);
    assign fifo_rdata = fifo_mem_q[rd_ptr_q];

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({wr_en, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    // ---------------------------------------------------------------- TX
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic            tx_last;

    // The last stop-bit cycle may already accept the next byte: frames run back to back.
    assign tx_last  = (tx_state_q == TxSend) && (tx_cnt_q == SymLast) && (tx_bit_q == 4'd9);
    assign tx_ready = (tx_state_q == TxIdle) || tx_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (pop) begin
            tx_state_d = TxSend;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, fifo_rdata, 1'b0};
        end else begin
            case (tx_state_q)
                TxSend: begin
                    if (tx_cnt_q == SymLast) begin
                        tx_cnt_d = '0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_d = TxIdle;
                        end else begin
                            tx_bit_d   = tx_bit_q + 1'b1;
                            tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        end
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    // Decoded from reset registers so an asserted reset drives the line high at once.
    assign serial_out = (tx_state_q == TxIdle) ? 1'b1 : tx_shift_q[0];

endmodule

// File: tb/tb_uart_echo_cpu.sv
// Directed bench for uart_echo_cpu: drives 8N1 frames, decodes the echo line and
// checks payload, order, bit timing and latency against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_echo_cpu;
    localparam int unsigned ClkFreq = 1_000_000;
    localparam int unsigned Baud    = 62_500;
    localparam int S    = ClkFreq / Baud;  // 16 cycles per bit
    localparam int Half = S / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b1;
    logic serial_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_t[$];
    bit         got_ok[$];
    int         mid_q[$];

    uart_echo_cpu #(
        .CPU_CLOCK_FREQ(ClkFreq),
        .BAUD_RATE(Baud),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .serial_in(serial_in),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: every cycle of every bit must hold the same level.
    initial begin : monitor
        int t0;
        logic [9:0] fr;
        bit ok, aborted;
        forever begin
            @(negedge clk);
            if (rst && serial_out === 1'b0) begin
                t0 = cyc; ok = 1'b1; aborted = 1'b0; fr = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < S; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst) aborted = 1'b1;
                        if (c == 0) fr[b] = serial_out;
                        else if (serial_out !== fr[b]) ok = 1'b0;
                    end
                end
                if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 1'b0;
                if (!aborted) begin
                    got_q.push_back(fr[8:1]);
                    got_t.push_back(t0);
                    got_ok.push_back(ok);
                end
            end
        end
    end

    function automatic logic [7:0] got_at(int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    function automatic bit ok_at(int i);
        return (i < got_ok.size()) ? got_ok[i] : 1'b0;
    endfunction

    function automatic int lat_at(int i);
        return (i < got_t.size() && i < mid_q.size()) ? got_t[i] - mid_q[i] : -999;
    endfunction

    task automatic clear_log();
        got_q.delete(); got_t.delete(); got_ok.delete(); mid_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered and left on a falling clock edge so consecutive calls abut exactly.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        serial_in = 1'b0;
        mid_q.push_back(cyc + 9 * S + Half);
        repeat (S) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            repeat (S) @(negedge clk);
        end
        serial_in = stop;
        repeat (S) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i = 0;
        while (got_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b0;
        serial_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_hold: low cycles %0d, required 0", bad);
        end
        rst = 1'b1;
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_line: low cycles %0d, required 0", bad);
        end
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL idle_frames: frames %0d, required 0", got_q.size());
        end
    endtask

    task automatic test_single_echo();
        int lat;
        clear_log();
        send_frame(8'h61, 1'b1);
        wait_frames(1, 20 * S);
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count: frames %0d, required 1", got_q.size());
        end
        checks++;
        if (got_at(0) !== 8'h61 || ok_at(0) !== 1'b1) begin
            errors++;
            $display("FAIL single_payload: got %h clean %0d, required 61 clean 1",
                     got_at(0), ok_at(0));
        end
        lat = lat_at(0);
        checks++;
        if (lat < 0 || lat > 5) begin
            errors++;
            $display("FAIL single_latency: %0d cycles after stop mid, required 0..5", lat);
        end
    endtask

    task automatic test_stream();
        int lat;
        clear_log();
        for (int i = 0; i < 10; i++) send_frame(8'h61 + 8'(i), 1'b1);
        wait_frames(10, 30 * S);
        checks++;
        if (got_q.size() !== 10) begin
            errors++;
            $display("FAIL stream_count: frames %0d, required 10", got_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_at(i) !== 8'h61 + 8'(i) || ok_at(i) !== 1'b1) begin
                errors++;
                $display("FAIL stream_payload[%0d]: got %h clean %0d, required %h clean 1",
                         i, got_at(i), ok_at(i), 8'h61 + 8'(i));
            end
            lat = lat_at(i);
            checks++;
            if (lat < 0 || lat > 5) begin
                errors++;
                $display("FAIL stream_latency[%0d]: %0d cycles, required 0..5", i, lat);
            end
        end
    endtask

    task automatic test_errors();
        clear_log();
        send_frame(8'h55, 1'b0);
        idle(3 * S);
        serial_in = 1'b0;
        idle(S / 4);
        serial_in = 1'b1;
        idle(3 * S);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL bad_frames_dropped: frames %0d, required 0", got_q.size());
        end
        clear_log();
        send_frame(8'h41, 1'b1);
        wait_frames(1, 20 * S);
        idle(12 * S);
        checks++;
        if (got_q.size() !== 1 || got_at(0) !== 8'h41 || ok_at(0) !== 1'b1) begin
            errors++;
            $display("FAIL recover_41: frames %0d byte %h, required 1 frame 41",
                     got_q.size(), got_at(0));
        end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        int bad = 0;
        clear_log();
        send_frame(8'h62, 1'b1);
        while (serial_out !== 1'b0 && i < 20 * S) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_echo_start: line %b, required 0", serial_out);
        end
        idle(4 * S);
        rst = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: line %b, required 1", serial_out);
        end
        repeat (10) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad++;
        end
        rst = 1'b1;
        repeat (12 * S) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_line_high: low cycles %0d, required 0", bad);
        end
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_partial: frames %0d, required 0", got_q.size());
        end
        clear_log();
        send_frame(8'h63, 1'b1);
        wait_frames(1, 20 * S);
        idle(20 * S);
        checks++;
        if (got_q.size() !== 1 || got_at(0) !== 8'h63 || ok_at(0) !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover_63: frames %0d byte %h, required 1 frame 63",
                     got_q.size(), got_at(0));
        end
    endtask

    task automatic test_overflow();
        clear_log();
        force dut.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1);
        idle(2 * S);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL overflow_stall: frames %0d, required 0", got_q.size());
        end
        release dut.tx_ready;
        wait_frames(8, 100 * S);
        idle(30 * S);
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL overflow_count: frames %0d, required 8", got_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_at(i) !== 8'h30 + 8'(i) || ok_at(i) !== 1'b1) begin
                errors++;
                $display("FAIL overflow_payload[%0d]: got %h clean %0d, required %h clean 1",
                         i, got_at(i), ok_at(i), 8'h30 + 8'(i));
            end
        end
        checks++;
        if (got_t.size() < 8 || got_t[7] - got_t[0] !== 70 * S) begin
            errors++;
            $display("FAIL back_to_back: span %0d cycles, required %0d",
                     (got_t.size() < 8) ? -1 : got_t[7] - got_t[0], 70 * S);
        end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_stream();
        test_errors();
        test_reset_mid();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
